// File: rtl/ifetch_unit_if.sv
// ---------------------------------------------------------------------------
// ifetch_unit_if -- instruction memory request/acknowledge bus.
//
// Signals:
//   imem_req    fetch request, driven by the fetch unit
//   imem_addr   word address of the request (32 bits)
//   imem_ack    request complete, driven by the memory
//   imem_rdata  instruction data, valid only in the ack cycle (32 bits)
//
// Modports:
//   master  fetch unit side (drives req/addr)
//   slave   memory side (drives ack/rdata)
// ---------------------------------------------------------------------------
interface ifetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (output imem_req, output imem_addr,
                  input  imem_ack, input  imem_rdata);
  modport slave  (input  imem_req, input  imem_addr,
                  output imem_ack, output imem_rdata);
endinterface

// File: rtl/ifetch_unit.sv
// ---------------------------------------------------------------------------
// ifetch_unit -- instruction fetch stage with a single-entry output register.
//
// Sequences fetch addresses, issues requests on the imem bus, captures the
// returned instruction into a one-deep IF/ID holding register, honours stall
// and redirect from later stages, and halts in a fault state on a memory
// timeout or a misaligned redirect target.
//
// Parameters:
//   RESET_PC      first fetch address after reset
//   IMEM_TIMEOUT  request cycles without ack before faulting (2..255)
//
// Ports:
//   clk          single clock, rising edge
//   reset        synchronous, active-high
//   stall        downstream cannot take an instruction this cycle
//   redirect     new fetch address from a later stage (highest priority)
//   redirect_pc  target address, sampled when redirect=1
//   imem         instruction memory bus (master side)
//   if_valid     if_instr/if_pcplus4 hold a live instruction
//   if_instr     held instruction
//   if_pcplus4   address of held instruction + 4
//   if_fault     fetch halted by timeout or misaligned target
//   fault_pc     offending address
//
// Optional feature (macro IFETCH_PERF_CNT_EN):
//   fetch_count  number of completed transfers (wraps at 2^32)
//   stall_count  cycles with a held instruction blocked by stall
// ---------------------------------------------------------------------------
module ifetch_unit #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned IMEM_TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               redirect,
  input  logic [31:0]        redirect_pc,
  ifetch_unit_if.master      imem,
  output logic               if_valid,
  output logic [31:0]        if_instr,
  output logic [31:0]        if_pcplus4,
  output logic               if_fault,
  output logic [31:0]        fault_pc
`ifdef IFETCH_PERF_CNT_EN
  ,
  output logic [31:0]        fetch_count,
  output logic [31:0]        stall_count
`endif
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    FAULT = 2'd2
  } state_e;

  // Wait count at which the next un-acked request cycle trips the timeout.
  localparam logic [7:0] TIMEOUT_LAST = 8'(IMEM_TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [31:0] pc_q;
  logic [7:0]  wait_q;
  logic        req;
  logic        transfer;
  logic        consume;
  logic        timeout_hit;
  logic        misaligned;

  assign misaligned     = (redirect_pc[1:0] != 2'b00);
  assign transfer       = req & imem.imem_ack;
  assign consume        = if_valid & ~stall;
  assign imem.imem_req  = req;
  assign imem.imem_addr = pc_q;

  // State register.
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (reset) state_q <= BOOT;
    else       state_q <= state_d;
  end

  // Next state and Moore/Mealy outputs.
  // NOTE: every signal written here gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    req         = 1'b0;
    if_fault    = 1'b0;
    timeout_hit = 1'b0;
    case (state_q)
      BOOT:  state_d = FETCH;
      FETCH: begin
        // A full output register that cannot drain blocks new requests.
        req         = ~redirect & ~reset & (~if_valid | ~stall);
        timeout_hit = req & ~imem.imem_ack & (wait_q == TIMEOUT_LAST);
        if (timeout_hit) state_d = FAULT;
      end
      FAULT: if_fault = 1'b1;
      default: state_d = BOOT;
    endcase
    // Redirect overrides everything, including leaving FAULT.
    if (redirect) state_d = misaligned ? FAULT : FETCH;
  end

  // PC, output register, fault address and request wait counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      if_valid   <= 1'b0;
      if_instr   <= 32'h0;
      if_pcplus4 <= 32'h0;
      fault_pc   <= 32'h0;
      wait_q     <= 8'h0;
    end else if (redirect) begin
      // Any same-cycle ack is dropped since req is forced low.
      if_valid <= 1'b0;
      wait_q   <= 8'h0;
      if (misaligned) fault_pc <= redirect_pc;
      else            pc_q     <= redirect_pc;
    end else begin
      if (transfer) begin
        if_instr   <= imem.imem_rdata;
        if_pcplus4 <= pc_q + 32'd4;
        if_valid   <= 1'b1;
        pc_q       <= pc_q + 32'd4;
      end else if (consume) begin
        if_valid <= 1'b0;
      end

      if (req & ~imem.imem_ack) begin
        wait_q <= timeout_hit ? 8'h0 : wait_q + 8'd1;
        if (timeout_hit) fault_pc <= pc_q;
      end else begin
        wait_q <= 8'h0;
      end
    end
  end

`ifdef IFETCH_PERF_CNT_EN
  // Performance counters survive redirects; only reset clears them.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_count <= 32'h0;
      stall_count <= 32'h0;
    end else begin
      if (transfer)          fetch_count <= fetch_count + 32'd1;
      if (if_valid & stall)  stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule

// File: doc/ifetch_unit.md
IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000: first fetch address after reset.
REQ-002 Parameter IMEM_TIMEOUT, 16: cycles imem_req may stay high without imem_ack before fault; range 2..255.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high.
REQ-005 stall  in  1  downstream IF/ID cannot take an instruction this cycle.
REQ-006 redirect  in  1  taken branch/jump/exception from later stage.
REQ-007 redirect_pc  in  32  new fetch address, sampled when redirect=1.
REQ-008 imem_req  out  1  fetch request; imem_addr  out  32  word address of request.
REQ-009 imem_ack  in  1  request complete; imem_rdata  in  32  instruction, valid only in ack cycle.
REQ-010 if_valid  out  1  if_instr/if_pcplus4 hold a live instruction.
REQ-011 if_instr  out  32; if_pcplus4  out  32  address of held instruction + 4.
REQ-012 if_fault  out  1  fetch halted by timeout or misaligned PC; fault_pc  out  32  offending address.

Function
REQ-013 States BOOT, FETCH, FAULT; reset enters BOOT; BOOT -> FETCH after exactly one cycle, imem_req=0 in BOOT.
REQ-014 imem_addr SHALL equal internal pc at all times; pc is 32-bit, pc+4 wraps modulo 2^32.
REQ-015 imem_req SHALL be 1 iff state=FETCH and redirect=0 and (if_valid=0 or stall=0).
REQ-016 Transfer = imem_req & imem_ack; ack while imem_req=0 SHALL be ignored.
REQ-017 On transfer: if_instr<=imem_rdata, if_pcplus4<=pc+4, if_valid<=1, pc<=pc+4; one-cycle latency ack->if_valid.
REQ-018 Output entry consumed when if_valid=1 and stall=0; consume without transfer SHALL clear if_valid.
REQ-019 While stall=1 and if_valid=1, if_instr/if_pcplus4/if_valid SHALL hold unchanged.
REQ-020 Back-to-back: transfer every cycle when ack=1 and stall=0, sustaining one instruction per cycle.
REQ-021 redirect=1 has priority over all else: pc<=redirect_pc, if_valid<=0, same-cycle ack discarded, wait counter cleared, state<=FETCH (also leaves FAULT).
REQ-022 redirect with redirect_pc[1:0]!=0: state<=FAULT, fault_pc<=redirect_pc, pc unchanged.
REQ-023 Wait counter increments each cycle imem_req=1 and ack=0; clears on transfer, on imem_req=0, on redirect.
REQ-024 Counter reaching IMEM_TIMEOUT: state<=FAULT, fault_pc<=pc, if_valid unchanged.
REQ-025 In FAULT: imem_req=0, if_fault=1, held entry still drains via stall rule; exit only by reset or aligned redirect.
REQ-026 if_fault SHALL be 0 in BOOT and FETCH.

Reset
REQ-027 reset=1 at a clock edge: state<=BOOT, pc<=RESET_PC, if_valid<=0, if_instr<=0, if_pcplus4<=0, fault_pc<=0, wait counter<=0.
REQ-028 reset SHALL override redirect, ack and stall in the same cycle; an in-flight request is abandoned.
REQ-029 imem_req SHALL be 0 during reset and the following BOOT cycle.

Configuration
REQ-030 Macro IFETCH_PERF_CNT_EN: when defined, add outputs fetch_count (32) and stall_count (32).
REQ-031 With macro: fetch_count +1 per transfer; stall_count +1 per cycle with if_valid=1 and stall=1; both reset to 0, wrap at 2^32, not cleared by redirect.
REQ-032 Without macro: those ports and counters SHALL not exist; all other behaviour identical.

Verification
REQ-033 Reset, ack tied 1, stall 0 -> imem_req=0 two cycles, then addrs 0x0,0x4,0x8; if_pcplus4 0x4,0x8,0xC one cycle after each ack.
REQ-034 if_valid=1 at pc 0x8, stall=1 for 3 cycles -> imem_req=0, if_instr/if_pcplus4=0xC held; resume fetch at 0xC on stall release.
REQ-035 redirect=1, redirect_pc=0x100 with ack same cycle -> rdata dropped, if_valid=0 next cycle, next imem_addr=0x100.
REQ-036 ack held 0 with IMEM_TIMEOUT=16 at pc 0x20 -> if_fault=1 after 16 request cycles, fault_pc=0x20, imem_req=0; redirect to 0x80 clears fault.
REQ-037 redirect_pc=0x102 -> FAULT, fault_pc=0x102; reset asserted mid-wait (counter=5) -> BOOT, pc=RESET_PC, counter=0.
REQ-038 With IFETCH_PERF_CNT_EN: 10 transfers and 4 stalled-valid cycles -> fetch_count=10, stall_count=4.
